// File: rtl/button_pkg.sv
// Shared types and default timing constants for the button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } btn_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY    = 50000000;
  localparam int DEF_REPEAT_PERIOD   = 10000000;

  // Counter width sized for the longest interval any channel must time.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single button channel: two-flop synchronizer, debounce FSM, press strobe.
// Optional auto-repeat enabled by defining BTN_AUTOREPEAT_EN.
module btn_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic             sync_p0;
  logic             sync_p1;
  btn_state_t       state;
  btn_state_t       state_nxt;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] db_cnt_nxt;
  logic             press_evt;
  logic             rpt_fire;

  // Stage p0/p1: metastability synchronizer on the raw pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  always_comb begin
    state_nxt  = state;
    db_cnt_nxt = db_cnt;
    case (state)
      RELEASED: begin
        if (sync_p1) begin
          state_nxt  = PRESS_PEND;
          db_cnt_nxt = '0;
        end
      end
      PRESS_PEND: begin
        if (!sync_p1) begin
          state_nxt  = RELEASED;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt  = PRESSED;
          db_cnt_nxt = '0;
        end else begin
          db_cnt_nxt = sat_inc(db_cnt);
        end
      end
      PRESSED: begin
        if (!sync_p1) begin
          state_nxt  = RELEASE_PEND;
          db_cnt_nxt = '0;
        end
      end
      RELEASE_PEND: begin
        if (sync_p1) begin
          state_nxt  = PRESSED;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt  = RELEASED;
          db_cnt_nxt = '0;
        end else begin
          db_cnt_nxt = sat_inc(db_cnt);
        end
      end
      default: begin
        state_nxt  = RELEASED;
        db_cnt_nxt = '0;
      end
    endcase
  end

  // A return from RELEASE_PEND to PRESSED is a bounce, not a new press.
  assign press_evt = (state == PRESS_PEND) && (state_nxt == PRESSED);

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rpt_cnt;
  logic             rpt_first;
  logic             rpt_hold;

  // Only cycles spent stably in PRESSED advance the repeat timer.
  assign rpt_hold = (state == PRESSED) && (state_nxt == PRESSED);
  assign rpt_fire = rpt_hold && (rpt_cnt == (rpt_first ? RPT_FIRST : RPT_NEXT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (press_evt) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
    end else if (rpt_hold) begin
      rpt_cnt   <= sat_inc(rpt_cnt);
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // Stage p2: FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RELEASED;
      db_cnt <= '0;
      level  <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      state  <= state_nxt;
      db_cnt <= db_cnt_nxt;
      level  <= (state_nxt == PRESSED) || (state_nxt == RELEASE_PEND);
      pulse  <= press_evt || rpt_fire;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Debounced level and press strobe for N_BTN independent push buttons.
// Define BTN_AUTOREPEAT_EN to add held-button auto-repeat strobes.
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  input  logic [N_BTN-1:0] BTN_RAW,
  output logic [N_BTN-1:0] BTN_LEVEL,
  output logic [N_BTN-1:0] BTN_PULSE
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_btn (
      .clk   (CLK100MHZ),
      .rst_n (CPU_RESETN),
      .raw   (BTN_RAW[i]),
      .level (BTN_LEVEL[i]),
      .pulse (BTN_PULSE[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random
// button activity compared against a run-length reference model.
`timescale 1ns/1ps
module tb_button_conditioner;

  localparam int N  = 3;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [N-1:0] raw;
  logic [N-1:0] level;
  logic [N-1:0] pulse;

  int checks;
  int failures;

  // Reference model state: synchronizer image, accepted level, strobe,
  // length of the current disagreeing run, and cycles held while pressed.
  logic [N-1:0] m_s0, m_s1, m_in, m_lvl, m_pul;
  int           run [N];
  int           rep [N];

  button_conditioner #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .BTN_RAW    (raw),
    .BTN_LEVEL  (level),
    .BTN_PULSE  (pulse)
  );

  initial clk = 1'b0;
  always #400 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s0 = '0; m_s1 = '0; m_in = '0; m_lvl = '0; m_pul = '0;
    for (int i = 0; i < N; i++) begin
      run[i] = 0;
      rep[i] = 0;
    end
  endtask

  // A new level is accepted once the synchronized input has disagreed with
  // it for D+1 consecutive samples.
  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_in  = m_s1;
    m_s1  = m_s0;
    m_s0  = raw;
    m_pul = '0;
    for (int i = 0; i < N; i++) begin
      if (m_in[i] != m_lvl[i]) begin
        run[i]++;
        if (run[i] == D + 1) begin
          m_lvl[i] = m_in[i];
          run[i]   = 0;
          if (m_in[i]) begin
            m_pul[i] = 1'b1;
            rep[i]   = 0;
          end
        end
      end else begin
        if (m_lvl[i] && run[i] == 0) begin
          rep[i]++;
          if (AR && (rep[i] == RD || (rep[i] > RD && (rep[i] - RD) % RP == 0)))
            m_pul[i] = 1'b1;
        end
        run[i] = 0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_level", level, m_lvl);
    chk("model_pulse", pulse, m_pul);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    raw      = 3'b111;
    model_reset();

    // Buttons held while reset is asserted
    repeat (3) begin
      cyc();
      chk("rst_level", level, 3'b000);
      chk("rst_pulse", pulse, 3'b000);
    end

    // Held across reset release: full debounce, level and strobe at 6
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cyc();
      chk("hold_rel_level", level, (k >= 6) ? 3'b111 : 3'b000);
      chk("hold_rel_pulse", pulse, (k == 6) ? 3'b111 : 3'b000);
    end

    // Reset while pressed clears outputs without waiting for a clock
    #100;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_level", level, 3'b000);
    chk("async_rst_pulse", pulse, 3'b000);
    repeat (2) cyc();
    rst_n = 1'b1;
    raw   = 3'b000;
    repeat (10) cyc();

    // Short glitch on channel 1
    raw = 3'b010;
    for (int k = 0; k < 15; k++) begin
      if (k == 3) raw = 3'b000;
      cyc();
      chk("glitch_level", level & 3'b010, 3'b000);
      chk("glitch_pulse", pulse & 3'b010, 3'b000);
    end

    // Clean press held for 20 cycles
    for (int k = 0; k < 32; k++) begin
      raw = (k < 20) ? 3'b010 : 3'b000;
      cyc();
      chk("hold_pulse", pulse & 3'b010,
          ((k == 6) || (AR && (k == 16 || k == 21))) ? 3'b010 : 3'b000);
      chk("hold_level", level & 3'b010, (k >= 6 && k < 26) ? 3'b010 : 3'b000);
    end

    // Bouncing release: level falls 6 cycles after the last edge
    raw = 3'b010;
    repeat (8) cyc();
    for (int k = 0; k < 14; k++) begin
      raw = (k == 1 || k == 3) ? 3'b010 : 3'b000;
      cyc();
      chk("bounce_level", level & 3'b010, (k < 10) ? 3'b010 : 3'b000);
      chk("bounce_pulse", pulse & 3'b010, 3'b000);
    end

    // Reset mid press-pending discards the partial count
    raw = 3'b111;
    repeat (4) cyc();
    #100;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("pend_rst_level", level, 3'b000);
    chk("pend_rst_pulse", pulse, 3'b000);
    repeat (2) cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("pend_rel_pulse", pulse, (k == 6) ? 3'b111 : 3'b000);
      chk("pend_rel_level", level, (k >= 6) ? 3'b111 : 3'b000);
    end
    raw = 3'b000;
    repeat (10) cyc();

    // Random activity: alternating bouncy and slow blocks, one reset
    for (int blk = 0; blk < 6; blk++) begin
      int rate;
      rate = (blk % 2 == 1) ? 30 : 3;
      for (int c = 0; c < 100; c++) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(rate - 1, 0) == 0) raw[i] = ~raw[i];
        if (blk == 3 && c == 50) begin
          rst_n = 1'b0;
          model_reset();
        end
        if (blk == 3 && c == 53) rst_n = 1'b1;
        cyc();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_BTN, default 3, number of independent button channels (bit 0 = BTNU, 1 = BTNC, 2 = BTND at top level).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz), cycles a synchronized input must hold a new value before it is accepted; legal range 2..2^24.
REQ-003 Parameter REPEAT_DELAY, default 50000000, cycles a button must be held before the first auto-repeat pulse.
REQ-004 Parameter REPEAT_PERIOD, default 10000000, cycles between subsequent auto-repeat pulses.
REQ-005 CLK100MHZ  input  1  sole clock, rising edge.
REQ-006 CPU_RESETN  input  1  asynchronous, active-low reset.
REQ-007 BTN_RAW  input  N_BTN  raw asynchronous button levels, active-high.
REQ-008 BTN_LEVEL  output  N_BTN  debounced registered level per channel.
REQ-009 BTN_PULSE  output  N_BTN  single-cycle press strobe per channel, consumed directly by the downstream lab design.

Function
REQ-010 Each BTN_RAW bit SHALL pass through a two-flop synchronizer before any other logic.
REQ-011 Each channel SHALL run an independent FSM: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
REQ-012 RELEASED -> PRESS_PEND when synchronized input = 1; PRESSED -> RELEASE_PEND when synchronized input = 0; debounce counter cleared on entry.
REQ-013 In a *_PEND state the counter SHALL increment each cycle the synchronized input holds the new value, and the FSM SHALL return to the prior stable state with counter cleared on any cycle it reverts.
REQ-014 PRESS_PEND -> PRESSED and RELEASE_PEND -> RELEASED when the counter reaches DEBOUNCE_CYCLES-1 with input still at the new value.
REQ-015 BTN_LEVEL SHALL be 1 exactly in PRESSED and RELEASE_PEND, registered; raw-edge-to-BTN_LEVEL latency for a clean edge is DEBOUNCE_CYCLES+2 cycles.
REQ-016 BTN_PULSE SHALL assert for exactly one cycle, in the same cycle BTN_LEVEL rises; no pulse on release.
REQ-017 Glitches shorter than DEBOUNCE_CYCLES SHALL produce no change on BTN_LEVEL or BTN_PULSE.
REQ-018 Simultaneous presses on several channels SHALL produce simultaneous, independent pulses; no arbitration.
REQ-019 Counter width SHALL be $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) and SHALL saturate, never wrap.

Reset
REQ-020 CPU_RESETN low SHALL immediately force all channels to RELEASED, all synchronizer flops, counters, BTN_LEVEL and BTN_PULSE to 0.
REQ-021 A button held across reset release SHALL be treated as a new press requiring the full debounce time; reset mid-PEND discards the partial count.

Configuration
REQ-022 With BTN_AUTOREPEAT_EN defined, a channel in PRESSED SHALL emit BTN_PULSE after REPEAT_DELAY cycles of continuous PRESSED, then every REPEAT_PERIOD cycles until leaving PRESSED; the repeat counter restarts on each entry to PRESSED and freezes in RELEASE_PEND, resuming if the FSM returns to PRESSED.
REQ-023 Without BTN_AUTOREPEAT_EN, only the single press pulse of REQ-016 SHALL exist, and REPEAT_DELAY/REPEAT_PERIOD SHALL be ignored with no repeat logic synthesized.

Structure
REQ-024 Shared package button_pkg SHALL hold the channel-state enum (btn_state_t) and default constants for DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD.
REQ-025 One sub-module btn_debounce SHALL implement a single channel (synchronizer, FSM, counters), instantiated N_BTN times by generate loop.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, 800 ns clock period)
REQ-026 Reset held, BTN_RAW=3'b111 -> BTN_LEVEL=0, BTN_PULSE=0; release reset -> BTN_LEVEL[2:0]=111 exactly 6 cycles later, one-cycle BTN_PULSE=111.
REQ-027 BTN_RAW[1] high for 3 cycles then low -> BTN_LEVEL[1] and BTN_PULSE[1] stay 0 throughout.
REQ-028 BTN_RAW[1] clean press held 20 cycles -> BTN_PULSE[1] high for exactly 1 cycle at cycle 6; with BTN_AUTOREPEAT_EN, additional pulses at cycles 16 and 21 only.
REQ-029 Release bouncing 1-0-1-0 then steady 0 -> BTN_LEVEL[1] falls 6 cycles after last edge, no pulse on release.
REQ-030 CPU_RESETN pulsed low during PRESS_PEND (cycle 3 of press) -> outputs 0 immediately; with BTN_RAW held, BTN_PULSE fires 6 cycles after reset release, once.
